seg_scan_param: RTL and testbench

SEG_SCAN_PARAM -- requirements
Module: seg_scan_param

---
 rtl/seg_scan_param_if.sv | 32 +++
 rtl/seg_scan_param.sv | 138 +++++++++++++
 tb/tb_seg_scan_param.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_param_if.sv
// Display bus for seg_scan_param.
//   number     : 4*DIGITS value to show, nibble 0 = rightmost digit
//   dp_in      : per-digit decimal point request
//   en         : display enable (0 blanks outputs, scanning continues)
//   dis_duan   : one-hot digit select, bit i = digit i
//   dis_wei    : segments a..g on bits 6..0, active high
//   dp         : decimal point of the selected digit
//   result     : raw nibble of the selected digit
//   frame_done : one-cycle pulse at the end of each scan frame
// master drives value/enable (user side), slave is the scanner.
interface seg_scan_param_if #(
   parameter int DIGITS = 4
);
   logic [4*DIGITS-1:0] number;
   logic [DIGITS-1:0]   dp_in;
   logic                en;
   logic [DIGITS-1:0]   dis_duan;
   logic [6:0]          dis_wei;
   logic                dp;
   logic [3:0]          result;
   logic                frame_done;

   modport master (
      output number, dp_in, en,
      input  dis_duan, dis_wei, dp, result, frame_done
   );

   modport slave (
      input  number, dp_in, en,
      output dis_duan, dis_wei, dp, result, frame_done
   );
endinterface

// File: rtl/seg_scan_param.sv
// Multiplexed seven-segment display scanner.
// Each digit is shown for DIV clk cycles; DIGITS slots form one frame.
// The displayed value and decimal points are captured in a shadow at the
// start of every frame so a frame never mixes two input values.
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : seg_scan_param_if slave (number, dp_in, en in;
//           dis_duan, dis_wei, dp, result, frame_done out, all registered)
module seg_scan_param #(
   parameter int DIGITS   = 4,
   parameter int DIV      = 50000,
   parameter int HEX_EN   = 1,
   parameter int BLANK_LZ = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   seg_scan_param_if.slave   bus
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int PW = $clog2(DIV);
   localparam int NW = 4 * DIGITS;

   logic [PW-1:0]     pcnt_q, pcnt_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [NW-1:0]     num_q, num_d;
   logic [DIGITS-1:0] dpin_q, dpin_d;
   logic [DIGITS-1:0] duan_q, duan_d;
   logic [6:0]        wei_q, wei_d;
   logic              dp_q, dp_d;
   logic [3:0]        res_q, res_d;
   logic              fd_q, fd_d;

   logic              slot_end;
   logic              load;
   logic [NW-1:0]     src_num;
   logic [DIGITS-1:0] src_dp;
   logic [3:0]        nib;
   logic              nib_dp;
   logic              upper_nz;
   logic [6:0]        seg;

   always_comb begin
      slot_end = (pcnt_q == PW'(DIV - 1));
      load     = (pcnt_q == '0) && (idx_q == '0);

      pcnt_d = slot_end ? '0 : pcnt_q + PW'(1);
      if (slot_end)
         idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
      else
         idx_d = idx_q;

      num_d  = load ? bus.number : num_q;
      dpin_d = load ? bus.dp_in  : dpin_q;

      // In the load cycle the shadow is being written on this same edge,
      // so decode from the live input; the digit shown for slot 0 then
      // matches the shadow for the rest of the frame.
      src_num = num_d;
      src_dp  = dpin_d;

      // idx_q and the shadow are constant within a slot, so recomputing
      // every cycle holds the outputs for the whole slot.
      nib      = '0;
      nib_dp   = 1'b0;
      upper_nz = 1'b0;
      for (int unsigned j = 0; j < DIGITS; j++) begin
         if (IW'(j) == idx_q) begin
            nib    = src_num[4*j +: 4];
            nib_dp = src_dp[j];
         end
         if ((IW'(j) >= idx_q) && (src_num[4*j +: 4] != 4'h0))
            upper_nz = 1'b1;
      end

      case (nib)
         4'h0:    seg = 7'b1111110;
         4'h1:    seg = 7'b0110000;
         4'h2:    seg = 7'b1101101;
         4'h3:    seg = 7'b1111001;
         4'h4:    seg = 7'b0110011;
         4'h5:    seg = 7'b1011011;
         4'h6:    seg = 7'b1011111;
         4'h7:    seg = 7'b1110000;
         4'h8:    seg = 7'b1111111;
         4'h9:    seg = 7'b1111011;
         4'hA:    seg = 7'b1110111;
         4'hB:    seg = 7'b0011111;
         4'hC:    seg = 7'b1001110;
         4'hD:    seg = 7'b0111101;
         4'hE:    seg = 7'b1001111;
         default: seg = 7'b1000111;
      endcase
      if ((HEX_EN == 0) && (nib > 4'h9))
         seg = '0;
      // Leading-zero blanking: digit 0 always shows.
      if ((BLANK_LZ != 0) && (idx_q != '0) && !upper_nz)
         seg = '0;

      duan_d = bus.en ? (DIGITS'(1) << idx_q) : '0;
      wei_d  = bus.en ? seg : '0;
      dp_d   = bus.en & nib_dp;
      res_d  = nib;
      fd_d   = slot_end && (idx_q == IW'(DIGITS - 1));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pcnt_q <= '0;
         idx_q  <= '0;
         num_q  <= '0;
         dpin_q <= '0;
         duan_q <= '0;
         wei_q  <= '0;
         dp_q   <= 1'b0;
         res_q  <= '0;
         fd_q   <= 1'b0;
      end else begin
         pcnt_q <= pcnt_d;
         idx_q  <= idx_d;
         num_q  <= num_d;
         dpin_q <= dpin_d;
         duan_q <= duan_d;
         wei_q  <= wei_d;
         dp_q   <= dp_d;
         res_q  <= res_d;
         fd_q   <= fd_d;
      end
   end

   assign bus.dis_duan   = duan_q;
   assign bus.dis_wei    = wei_q;
   assign bus.dp         = dp_q;
   assign bus.result     = res_q;
   assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_param.sv
// Bench for seg_scan_param: four instances (hex, no-hex, leading-zero
// blanking, single digit) share clock, reset and stimulus. Expected
// outputs come from a time-based model: cycle c after reset release is
// slot c/DIV, digit (c/DIV)%DIGITS, frame value captured at c%(DIV*DIGITS)==0.
module tb_seg_scan_param;

   typedef struct {
      logic [3:0] duan;
      logic [6:0] w0, w1, w2;
      logic       dp;
      logic [3:0] res;
      logic       fd;
      logic       d3;
      logic [6:0] w3;
      logic       dp3;
      logic [3:0] r3;
      logic       fd3;
   } exp_t;

   localparam logic [6:0] SEG [16] = '{
      7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
      7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
   };

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   seg_scan_param_if #(.DIGITS(4)) b0 ();
   seg_scan_param_if #(.DIGITS(4)) b1 ();
   seg_scan_param_if #(.DIGITS(4)) b2 ();
   seg_scan_param_if #(.DIGITS(1)) b3 ();

   seg_scan_param #(.DIGITS(4), .DIV(4), .HEX_EN(1), .BLANK_LZ(0))
      u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
   seg_scan_param #(.DIGITS(4), .DIV(4), .HEX_EN(0), .BLANK_LZ(0))
      u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
   seg_scan_param #(.DIGITS(4), .DIV(4), .HEX_EN(1), .BLANK_LZ(1))
      u2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
   seg_scan_param #(.DIGITS(1), .DIV(3), .HEX_EN(1), .BLANK_LZ(0))
      u3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

   int   errs   = 0;
   int   checks = 0;
   int   c      = 0;
   logic [15:0] fv  = '0;
   logic [3:0]  fdp = '0;
   logic [3:0]  fv3 = '0;
   logic        fdp3 = 1'b0;
   exp_t q [$];

   task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s got=%h want=%h c=%0d t=%0t", tag, act, exp, c, $time);
      end
   endtask

   function automatic logic [6:0] segf(input logic [3:0] n, input bit hex);
      if (!hex && n > 4'h9) return '0;
      return SEG[n];
   endfunction

   task automatic drive(input logic [15:0] num, input logic [3:0] dpv, input logic en);
      b0.number = num; b1.number = num; b2.number = num; b3.number = num[3:0];
      b0.dp_in  = dpv; b1.dp_in  = dpv; b2.dp_in  = dpv; b3.dp_in  = dpv[0];
      b0.en = en; b1.en = en; b2.en = en; b3.en = en;
   endtask

   // Push expectation for the coming edge, clock it, then pop and compare.
   task automatic cyc();
      exp_t e, g;
      int   k;
      logic [3:0]  nib;
      logic [15:0] up;
      logic        en;
      en = b0.en;
      if (!rst_n) begin
         e = '{default: '0};
         c = 0;
      end else begin
         if (c % 16 == 0) begin fv = b0.number; fdp = b0.dp_in; end
         if (c % 3 == 0)  begin fv3 = b3.number; fdp3 = b3.dp_in[0]; end
         k   = (c / 4) % 4;
         up  = fv >> (4 * k);
         nib = up[3:0];
         e.duan = en ? (4'b0001 << k) : 4'b0000;
         e.w0   = en ? segf(nib, 1'b1) : '0;
         e.w1   = en ? segf(nib, 1'b0) : '0;
         e.w2   = (en && !(k > 0 && up == 16'h0)) ? segf(nib, 1'b1) : '0;
         e.dp   = en & fdp[k];
         e.res  = nib;
         e.fd   = (c % 16 == 15);
         e.d3   = en;
         e.w3   = en ? segf(fv3, 1'b1) : '0;
         e.dp3  = en & fdp3;
         e.r3   = fv3;
         e.fd3  = (c % 3 == 2);
         c++;
      end
      q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      g = q.pop_front();
      chk("duan0", 16'(b0.dis_duan), 16'(g.duan));
      chk("wei0",  16'(b0.dis_wei),  16'(g.w0));
      chk("dp0",   16'(b0.dp),       16'(g.dp));
      chk("res0",  16'(b0.result),   16'(g.res));
      chk("fd0",   16'(b0.frame_done), 16'(g.fd));
      chk("duan1", 16'(b1.dis_duan), 16'(g.duan));
      chk("wei1",  16'(b1.dis_wei),  16'(g.w1));
      chk("res1",  16'(b1.result),   16'(g.res));
      chk("duan2", 16'(b2.dis_duan), 16'(g.duan));
      chk("wei2",  16'(b2.dis_wei),  16'(g.w2));
      chk("dp2",   16'(b2.dp),       16'(g.dp));
      chk("duan3", 16'(b3.dis_duan), 16'(g.d3));
      chk("wei3",  16'(b3.dis_wei),  16'(g.w3));
      chk("dp3",   16'(b3.dp),       16'(g.dp3));
      chk("res3",  16'(b3.result),   16'(g.r3));
      chk("fd3",   16'(b3.frame_done), 16'(g.fd3));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   // Advance until the model cycle counter reaches phase p within a frame.
   task automatic align(input int p);
      for (int i = 0; i < 16 && (c % 16) != p; i++) cyc();
   endtask

   initial begin
      drive(16'h0000, 4'h0, 1'b1);
      rst_n = 1'b0;
      run(3);
      rst_n = 1'b1;

      // Basic scan 1234
      drive(16'h1234, 4'b0010, 1'b1);
      run(32);

      // Hex digits vs blanked hex
      align(0);
      drive(16'h00AF, 4'b1000, 1'b1);
      run(32);

      // Leading-zero blanking
      drive(16'h0050, 4'b0101, 1'b1);
      run(32);
      drive(16'h0000, 4'b0110, 1'b1);
      run(16);

      // Mid-frame change lands at the next frame only
      drive(16'h1111, 4'h0, 1'b1);
      align(0);
      run(9);
      drive(16'h2222, 4'h0, 1'b1);
      run(23);

      // Enable low for slot 1 of one frame
      align(0);
      for (int i = 0; i < 32; i++) begin
         drive(16'h2222, 4'hF, !(i >= 4 && i < 8));
         cyc();
      end

      // One-cycle reset in slot 3
      drive(16'h9876, 4'h3, 1'b1);
      align(13);
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      drive(16'h0C0D, 4'h8, 1'b1);
      run(24);

      // Random values changing at arbitrary cycles
      for (int i = 0; i < 96; i++) begin
         if (i % 5 == 0)
            drive(16'($urandom), 4'($urandom), ($urandom_range(0, 7) != 0));
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
